timer_down_8bit: RTL and testbench

TIMER_DOWN_8BIT -- requirements
Module: timer_down_8bit

---
 rtl/timer_down_8bit.sv | 73 +++++++
 tb/tb_timer_down_8bit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/timer_down_8bit.sv
// timer_down_8bit: loadable 8-bit down counter with start/stop,
// auto-reload and a one-cycle terminal-count pulse.
module timer_down_8bit (
  input  logic       clk,
  input  logic       clr,
  input  logic       l,
  input  logic       s_s,
  input  logic       ar,
  input  logic [7:0] d,
  output logic [7:0] c,
  output logic       tc,
  output logic       run
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  logic [7:0] r;

  always_ff @(posedge clk) begin
    if (clr) begin
      c     <= 8'd0;
      r     <= 8'd0;
      tc    <= 1'b0;
      run   <= 1'b0;
      state <= IDLE;
    end else if (l) begin
      c  <= d;
      r  <= d;
      tc <= 1'b0;
      if (state == DONE)
        state <= IDLE;
    end else begin
      tc <= 1'b0;
      unique case (state)
        IDLE: begin
          // entering RUN costs one edge; no decrement here
          if (s_s && c != 8'd0) begin
            state <= RUN;
            run   <= 1'b1;
          end
        end
        RUN: begin
          if (!s_s) begin
            state <= IDLE;
            run   <= 1'b0;
          end else if (c > 8'd1) begin
            c <= c - 8'd1;
          end else if (c == 8'd1) begin
            c  <= 8'd0;
            tc <= 1'b1;
          end else if (ar && r != 8'd0) begin
            c <= r;
          end else begin
            state <= DONE;
            run   <= 1'b0;
          end
        end
        DONE: begin
        end
        default: begin
          state <= IDLE;
          run   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_down_8bit.sv
// tb_timer_down_8bit: directed scenarios plus randomized traffic
// checked against a behavioural model of the timer.
module tb_timer_down_8bit;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       l   = 1'b0;
  logic       s_s = 1'b0;
  logic       ar  = 1'b0;
  logic [7:0] d   = 8'd0;
  logic [7:0] c;
  logic       tc;
  logic       run;

  int checks   = 0;
  int failures = 0;

  // model: count, reload value, counting / finished flags
  int  m_c = 0;
  int  m_r = 0;
  bit  m_tc = 1'b0;
  bit  m_counting = 1'b0;
  bit  m_finished = 1'b0;
  bit  prev_tc = 1'b0;
  bit  have_prev = 1'b0;

  timer_down_8bit dut (
    .clk (clk),
    .clr (clr),
    .l   (l),
    .s_s (s_s),
    .ar  (ar),
    .d   (d),
    .c   (c),
    .tc  (tc),
    .run (run)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (clr) begin
      m_c = 0; m_r = 0; m_tc = 0;
      m_counting = 0; m_finished = 0;
    end else if (l) begin
      m_c = d; m_r = d; m_tc = 0;
      m_finished = 0;
    end else begin
      m_tc = 0;
      if (m_finished) begin
      end else if (!m_counting) begin
        if (s_s && m_c != 0) m_counting = 1;
      end else if (!s_s) begin
        m_counting = 0;
      end else if (m_c >= 1) begin
        m_c = m_c - 1;
        m_tc = (m_c == 0);
      end else if (ar && m_r != 0) begin
        m_c = m_r;
      end else begin
        m_counting = 0;
        m_finished = 1;
      end
    end
  endtask

  task automatic step(input logic i_clr, input logic i_l,
                      input logic i_ss, input logic i_ar,
                      input logic [7:0] i_d);
    clr = i_clr; l = i_l; s_s = i_ss; ar = i_ar; d = i_d;
    @(posedge clk);
    model_edge();
    #1;
    chk("model_c", c, 8'(m_c));
    chk("model_tc", {7'd0, tc}, {7'd0, m_tc});
    chk("model_run", {7'd0, run}, {7'd0, m_counting});
    if (have_prev) begin
      chk("tc_not_back_to_back", {7'd0, prev_tc && tc}, 8'd0);
    end
    prev_tc = tc;
    have_prev = 1'b1;
  endtask

  initial begin
    // basic one-shot count 5..0 then DONE
    step(1, 0, 0, 0, 8'h00);
    chk("rst_c", c, 8'h00);
    chk("rst_tc", {7'd0, tc}, 8'd0);
    chk("rst_run", {7'd0, run}, 8'd0);
    step(0, 1, 0, 0, 8'h05);
    chk("load5_c", c, 8'h05);
    step(0, 0, 1, 0, 8'h00);
    chk("start_run", {7'd0, run}, 8'd1);
    chk("start_c", c, 8'h05);
    for (int i = 4; i >= 0; i--) begin
      step(0, 0, 1, 0, 8'h00);
      chk("one_shot_c", c, 8'(i));
      chk("one_shot_tc", {7'd0, tc}, (i == 0) ? 8'd1 : 8'd0);
    end
    step(0, 0, 1, 0, 8'h00);
    chk("done_run", {7'd0, run}, 8'd0);
    chk("done_c", c, 8'h00);

    // DONE ignores s_s / ar, leaves only via load
    step(0, 0, 0, 1, 8'h00);
    step(0, 0, 1, 1, 8'h00);
    step(0, 0, 1, 0, 8'h00);
    chk("done_hold_c", c, 8'h00);
    chk("done_hold_run", {7'd0, run}, 8'd0);
    step(0, 1, 1, 0, 8'h02);
    chk("done_load_c", c, 8'h02);
    chk("done_load_run", {7'd0, run}, 8'd0);
    step(0, 0, 1, 0, 8'h00);
    chk("done_restart_run", {7'd0, run}, 8'd1);
    step(0, 0, 1, 0, 8'h00);
    chk("two_to_one", c, 8'h01);
    step(0, 0, 1, 0, 8'h00);
    chk("two_to_zero_c", c, 8'h00);
    chk("two_to_zero_tc", {7'd0, tc}, 8'd1);

    // auto-reload period of 4
    step(1, 0, 0, 0, 8'h00);
    step(0, 1, 0, 1, 8'h03);
    step(0, 0, 1, 1, 8'h00);
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 1, 1, 8'h00);
      chk("ar_c", c, 8'(2 - (i % 4) + ((i % 4) == 3 ? 4 : 0)));
      chk("ar_tc", {7'd0, tc}, ((i % 4) == 2) ? 8'd1 : 8'd0);
      chk("ar_run", {7'd0, run}, 8'd1);
    end

    // pause and resume
    step(1, 0, 0, 0, 8'h00);
    step(0, 1, 0, 0, 8'hCD);
    step(0, 0, 1, 0, 8'h00);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 0, 8'h00);
    chk("pause_pre", c, 8'hC3);
    step(0, 0, 0, 0, 8'h00);
    chk("pause_c", c, 8'hC3);
    chk("pause_run", {7'd0, run}, 8'd0);
    step(0, 0, 0, 0, 8'h00);
    chk("pause_hold", c, 8'hC3);
    step(0, 0, 1, 0, 8'h00);
    chk("resume_c", c, 8'hC3);
    chk("resume_run", {7'd0, run}, 8'd1);
    step(0, 0, 1, 0, 8'h00);
    chk("resume_dec", c, 8'hC2);

    // reload value replaced mid-run
    step(1, 0, 0, 0, 8'h00);
    step(0, 1, 0, 1, 8'h50);
    step(0, 0, 1, 1, 8'h00);
    for (int i = 0; i < 16; i++) step(0, 0, 1, 1, 8'h00);
    chk("midload_pre", c, 8'h40);
    step(0, 1, 1, 1, 8'h10);
    chk("midload_c", c, 8'h10);
    chk("midload_run", {7'd0, run}, 8'd1);
    step(0, 0, 1, 1, 8'h00);
    chk("midload_dec", c, 8'h0F);
    for (int i = 0; i < 15; i++) step(0, 0, 1, 1, 8'h00);
    chk("midload_zero", c, 8'h00);
    step(0, 0, 1, 1, 8'h00);
    chk("midload_reload", c, 8'h10);

    // clear beats load mid-run, then stays idle
    step(1, 1, 1, 1, 8'h77);
    chk("clr_c", c, 8'h00);
    chk("clr_run", {7'd0, run}, 8'd0);
    step(0, 0, 1, 1, 8'h00);
    step(0, 0, 1, 1, 8'h00);
    chk("clr_idle_c", c, 8'h00);
    chk("clr_idle_run", {7'd0, run}, 8'd0);

    // load of zero while running: no tc, then DONE (r==0)
    step(0, 1, 0, 1, 8'h09);
    step(0, 0, 1, 1, 8'h00);
    step(0, 1, 1, 1, 8'h00);
    chk("zero_load_c", c, 8'h00);
    chk("zero_load_tc", {7'd0, tc}, 8'd0);
    step(0, 0, 1, 1, 8'h00);
    chk("zero_load_done", {7'd0, run}, 8'd0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic       rc, rl, rs, ra;
      logic [7:0] rd;
      rc = ($urandom_range(0, 63) == 0);
      rl = ($urandom_range(0, 15) == 0);
      rs = ($urandom_range(0, 7) != 0);
      ra = $urandom_range(0, 1) == 1;
      rd = ($urandom_range(0, 3) == 0) ? 8'($urandom) :
           8'($urandom_range(0, 6));
      step(rc, rl, rs, ra, rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
